// File: rtl/bench_bist_pkg.sv
// bench_bist_pkg: shared state encoding and LFSR constants for the BIST controller
package bench_bist_pkg;
  typedef enum logic [1:0] {IDLE, CORE_RST, RUN, DONE} state_t;
  localparam int LFSR_W = 24;
  localparam logic [LFSR_W-1:0] TAPS = 24'hE10000;
endpackage

// File: rtl/bist_lfsr24.sv
// bist_lfsr24: 24-bit Fibonacci shift register with parallel XOR input (generator or MISR)
module bist_lfsr24
  import bench_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RST_VAL = '0
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_en,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic [LFSR_W-1:0] i_par,
  output logic [LFSR_W-1:0] o_q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) o_q <= RST_VAL;
    else if (i_load) o_q <= i_seed;
    else if (i_en) o_q <= {o_q[LFSR_W-2:0], ^(o_q & TAPS)} ^ i_par;
endmodule

// File: rtl/bench_bist_ctrl.sv
// bench_bist_ctrl: holds the core in reset, drives LFSR patterns, compacts outputs into a MISR
// and reports pass/fail against a golden signature.
module bench_bist_ctrl
  import bench_bist_pkg::*;
#(
  parameter int                N_IN      = 18,
  parameter int                N_OUT     = 19,
  parameter int                PAT_W     = 16,
  parameter int                RST_CYC   = 2,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 24'h000001
)(
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start,
  input  logic              abort,
  input  logic [PAT_W-1:0]  n_patterns,
  input  logic [LFSR_W-1:0] golden_sig,
  input  logic [N_OUT-1:0]  core_out,
  output logic [N_IN-1:0]   core_in,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [LFSR_W-1:0] signature
);
  localparam int RC_W = $clog2(RST_CYC + 1);
  state_t r_state, w_next;
  logic [PAT_W-1:0] r_cnt, r_n;
  logic [LFSR_W-1:0] r_gold, r_sig, w_lfsr, w_misr;
  logic [RC_W-1:0] r_rc;
  logic r_pass, w_acc, w_run, w_unused;
  assign w_acc = r_state == IDLE && start && !abort;
  assign w_run = r_state == RUN;
  assign core_in = w_lfsr[N_IN-1:0];
  assign w_unused = ^w_lfsr;
  bist_lfsr24 #(.RST_VAL(LFSR_SEED)) u_gen (
    .clk(blif_clk_net), .rst(blif_reset_net), .i_load(w_acc), .i_en(w_run),
    .i_seed(LFSR_SEED), .i_par('0), .o_q(w_lfsr)
  );
  bist_lfsr24 #(.RST_VAL('0)) u_misr (
    .clk(blif_clk_net), .rst(blif_reset_net), .i_load(w_acc), .i_en(w_run),
    .i_seed('0), .i_par(LFSR_W'(core_out)), .o_q(w_misr)
  );
  always_ff @(posedge blif_clk_net or posedge blif_reset_net)
    if (blif_reset_net) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_n     <= '0;
      r_gold  <= '0;
      r_rc    <= '0;
      r_sig   <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rc    <= r_state == CORE_RST ? r_rc + 1'b1 : '0;
      if (w_acc) begin
        r_n    <= n_patterns;
        r_gold <= golden_sig;
        r_cnt  <= '0;
      end else if (w_run) r_cnt <= r_cnt + 1'b1;
      if (r_state == DONE) begin
        r_sig  <= w_misr;
        r_pass <= w_misr == r_gold;
      end
    end
  // Result outputs show the live verdict during DONE and the registered copy afterwards.
  always_comb begin
    w_next    = r_state;
    core_rst  = r_state == CORE_RST;
    busy      = r_state == CORE_RST || r_state == RUN;
    done      = r_state == DONE;
    pass      = r_state == DONE ? w_misr == r_gold : r_pass;
    signature = r_state == DONE ? w_misr : r_sig;
    if (abort) w_next = IDLE;
    else
      case (r_state)
        IDLE:     w_next = start ? CORE_RST : IDLE;
        CORE_RST: w_next = r_rc == RC_W'(RST_CYC - 1) ? (r_n == '0 ? DONE : RUN) : CORE_RST;
        RUN:      w_next = r_cnt == r_n - 1'b1 ? DONE : RUN;
        default:  w_next = IDLE;
      endcase
  end
endmodule

// File: tb/tb_bench_bist_ctrl.sv
// tb_bench_bist_ctrl: scoreboard bench; stimulus pushes expected results, a negedge monitor
// pops and compares them whenever done pulses.
module tb_bench_bist_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [15:0] n_patterns = '0;
  logic [23:0] golden_sig = '0;
  logic [18:0] core_out = '0;
  logic [17:0] core_in;
  logic core_rst, busy, done, pass;
  logic [23:0] signature;

  typedef struct {logic [23:0] sig; logic pass; int at;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [17:0] cap[$];
  bit cap_en = 0;
  int checks = 0, errors = 0, cyc = 0, ndone = 0, nrst = 0, st = 0, d0 = 0;

  bench_bist_ctrl dut (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start), .abort(abort),
    .n_patterns(n_patterns), .golden_sig(golden_sig), .core_out(core_out),
    .core_in(core_in), .core_rst(core_rst), .busy(busy), .done(done),
    .pass(pass), .signature(signature)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, x);
    end
  endtask

  always @(negedge clk) begin
    if (cap_en && busy && !core_rst) cap.push_back(core_in);
    if (cap_en && core_rst) nrst++;
    if (done) begin
      ndone++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        e = sb.pop_front();
        chk("signature", signature, e.sig);
        chk("pass", pass, e.pass);
        chk("done_cycle", cyc, e.at);
        chk("busy_in_done", busy, 0);
      end
    end
  end

  task automatic kick(input logic [15:0] n, input logic [23:0] g);
    n_patterns = n;
    golden_sig = g;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    st = cyc;
  endtask

  task automatic run(input logic [15:0] n, input logic [23:0] g, input logic [23:0] es, input logic ep);
    kick(n, g);
    sb.push_back('{es, ep, st + 2 + int'(n)});
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0 after %0d cycles", sb.size(), lim);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_core_in", core_in, 18'h00001);
    chk("rst_core_rst", core_rst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_signature", signature, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    // n=0: two reset cycles then DONE, empty signature
    nrst = 0;
    cap_en = 1;
    run(16'd0, 24'h0, 24'h0, 1'b1);
    wait_done(20);
    cap_en = 0;
    chk("core_rst_cycles", nrst, 2);
    core_out = 19'h00001;
    run(16'd2, 24'h000003, 24'h000003, 1'b1);
    wait_done(20);
    d0 = ndone;
    run(16'd2, 24'h000004, 24'h000003, 1'b0);
    wait_done(20);
    chk("single_done_pulse", ndone - d0, 1);
    // abort in the third RUN cycle
    d0 = ndone;
    kick(16'd5, 24'h0);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_core_rst", core_rst, 0);
    chk("abort_busy", busy, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", ndone - d0, 0);
    chk("abort_keeps_sig", signature, 24'h000003);
    chk("abort_keeps_pass", pass, 0);
    cap.delete();
    cap_en = 1;
    run(16'd2, 24'h000003, 24'h000003, 1'b1);
    wait_done(20);
    cap_en = 0;
    chk("rerun_len", cap.size(), 2);
    if (cap.size() == 2) begin
      chk("rerun_pat0", cap[0], 18'h00001);
      chk("rerun_pat1", cap[1], 18'h00002);
    end
    // abort and start together in IDLE
    d0 = ndone;
    abort = 1'b1;
    kick(16'd1, 24'h0);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_start_busy", busy, 0);
    chk("abort_start_core_rst", core_rst, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_start_no_done", ndone - d0, 0);
    // n=18 pattern sequence from the seed
    core_out = '0;
    cap.delete();
    cap_en = 1;
    run(16'd18, 24'h0, 24'h0, 1'b1);
    wait_done(40);
    cap_en = 0;
    chk("pat_count", cap.size(), 18);
    for (int k = 0; k < 18 && k < cap.size(); k++)
      chk($sformatf("pat%0d", k), cap[k], k < 17 ? 18'(1 << k) : 18'h20001);
    // start pulsed during RUN must not disturb latched n/golden
    core_out = 19'h00001;
    run(16'd4, 24'h00000F, 24'h00000F, 1'b1);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    n_patterns = 16'd1;
    golden_sig = 24'h0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(20);
    // asynchronous reset mid-RUN
    kick(16'd10, 24'h0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_core_rst", core_rst, 0);
    chk("arst_signature", signature, 0);
    chk("arst_pass", pass, 0);
    chk("arst_core_in", core_in, 18'h00001);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    // maximum pattern count: no early counter wrap
    core_out = '0;
    run(16'hFFFF, 24'h0, 24'h0, 1'b1);
    wait_done(70000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
